// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction constants, branch encodings
// and the fetch-stage state type.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_TAKEN = 2'b01,
    BR_JUMP  = 2'b10,
    BR_JR    = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits carry no meaning.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid, with write-enable,
// bubble-inserting flush (flush wins over write) and async active-low reset.
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        flush,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (wr_en) begin
      instr <= next_instr;
      pc4   <= next_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM (FETCH/HELD/DROP), one-entry hold
// buffer, pending redirect target and the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        IFIDFlush,
  input  logic [1:0]  Branch,
  input  logic [31:0] BranchTarget,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid,
  output logic        FetchStall
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  hold_instr;
  logic [31:0]  pending_pc;
  logic         req_q;

  logic         accept;
  logic         redirect;
  logic         stall;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;

  logic         ifid_we;
  logic         ifid_flush;
  logic [31:0]  ifid_next_instr;

  assign accept   = req_q & imem_ready;
  assign redirect = (Branch != BR_NONE);
  assign stall    = ~IFIDWrite | ~PCWrite;
  assign target   = align_word(BranchTarget);
  assign pc_plus4 = pc + 32'd4;

  // Address and request come straight from flops so they never glitch.
  assign imem_addr  = pc;
  assign imem_req   = req_q;
  assign FetchStall = (state == FETCH) & req_q & ~imem_ready;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_instr <= NOP_INSTR;
      pending_pc <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      req_q <= 1'b1;
      case (state)
        FETCH: begin
          if (redirect) begin
            if (accept) begin
              pc <= target;
            end else begin
              // Request in flight cannot be withdrawn; remember where to go.
              pending_pc <= target;
              state      <= DROP;
            end
          end else if (IFIDFlush) begin
            // Flush without redirect refetches the same PC.
          end else if (stall) begin
            if (accept) begin
              hold_instr <= imem_rdata;
              state      <= HELD;
              req_q      <= 1'b0;
            end
          end else if (accept) begin
            pc <= pc_plus4;
          end
        end
        HELD: begin
          if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (IFIDFlush || stall) begin
            req_q <= 1'b0;
          end else begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        DROP: begin
          if (redirect) begin
            if (accept) begin
              pc    <= target;
              state <= FETCH;
            end else begin
              pending_pc <= target;
            end
          end else if (accept) begin
            pc    <= pending_pc;
            state <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  always_comb begin
    ifid_we         = 1'b0;
    ifid_flush      = 1'b0;
    ifid_next_instr = imem_rdata;
    if (redirect || IFIDFlush) begin
      ifid_flush = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (accept) ifid_we    = ~stall;
          else        ifid_flush = IFIDWrite;
        end
        HELD: begin
          ifid_we         = ~stall;
          ifid_next_instr = hold_instr;
        end
        DROP: begin
          ifid_flush = IFIDWrite;
        end
        default: begin
          ifid_flush = 1'b1;
        end
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk        (Clk),
    .rst_n      (Reset),
    .wr_en      (ifid_we),
    .flush      (ifid_flush),
    .next_instr (ifid_next_instr),
    .next_pc4   (pc_plus4),
    .instr      (IFID_Instr),
    .pc4        (IFID_PC4),
    .valid      (IFID_Valid)
  );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC, drives the instruction-memory request, and holds the IF/ID pipeline register. It consumes PCWrite, IFIDWrite and IFIDFlush from hazard detection and the resolved Branch/target from the branch stage. It feeds decode with the IF/ID instruction and PC+4. It tolerates a variable-latency instruction memory through a req/ready handshake and a one-entry hold buffer.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- Clk  input  1  clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-low; asserting clears all state immediately
- PCWrite  input  1  from hazard detection; 0 freezes the PC
- IFIDWrite  input  1  from hazard detection; 0 holds IF/ID
- IFIDFlush  input  1  from hazard detection; 1 loads a bubble into IF/ID
- Branch  input  2  00 none, 01 taken branch, 10 jump, 11 jump-register; nonzero means redirect
- BranchTarget  input  32  redirect address, valid when Branch != 0
- imem_addr  output  32  fetch address
- imem_req  output  1  fetch request
- imem_ready  input  1  memory returns imem_rdata this cycle; same-cycle ready allowed
- imem_rdata  input  32  instruction word
- IFID_Instr  output  32  decode instruction; 0 (sll nop) when bubble
- IFID_PC4  output  32  PC+4 of IFID_Instr
- IFID_Valid  output  1  IF/ID holds a real instruction
- FetchStall  output  1  fetch is waiting on memory (FETCH state, imem_req=1, imem_ready=0)

## Operation
- States: FETCH (req=1, addr=PC), HELD (req=0, instruction buffered because IFIDWrite=0), DROP (req=1 at old address; response discarded after redirect).
- Accept = imem_req & imem_ready.
- Event priority per cycle: Reset > redirect (Branch != 0) > IFIDFlush > stall (IFIDWrite=0 or PCWrite=0) > normal.
- FETCH, accept, no stall: IF/ID <= {rdata, PC+4, Valid=1}, PC <= PC+4, stay in FETCH.
- FETCH, accept, stall: rdata goes to the hold buffer, PC unchanged, go to HELD. IF/ID keeps its contents.
- FETCH, no accept: if IFIDWrite=1, IF/ID <= bubble (Valid=0, Instr=0). Otherwise IF/ID holds.
- HELD, stall released: IF/ID <= buffer, PC <= PC+4, go to FETCH.
- Redirect from FETCH with accept, or from HELD: PC <= BranchTarget, buffer discarded, go to FETCH.
- Redirect from FETCH without accept: latch BranchTarget into the pending-target register and go to DROP. imem_addr stays stable, because the request cannot be withdrawn.
- DROP, accept: discard rdata, PC <= pending target, go to FETCH.
- A second redirect while in DROP overwrites the pending target.
- Every redirect forces an IF/ID bubble. IFIDFlush alone forces a bubble without changing the PC.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. The low 2 bits of BranchTarget are ignored and forced to 00.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, IFID_Instr=0, IFID_PC4=0, IFID_Valid=0, FetchStall=0, imem_req=0 while Reset is low.
- imem_addr=RESET_PC at reset. imem_req=1 from the first cycle after release.
- Zero-wait memory: one instruction per cycle. Request to IF/ID takes 1 edge.
- Redirect penalty with zero-wait memory: the target appears on imem_addr in the cycle after the Branch edge. The instruction fetched in the Branch cycle is squashed.
- imem_addr and imem_req are registered-state derived and glitch-free. imem_addr must not change while req=1 and ready=0.
- Reset asserted mid-DROP or mid-HELD: the buffer and pending target are cleared, and fetch restarts at RESET_PC.

## Structure
- Shared package mips_pkg holds:
  - NOP_INSTR = 32'h0
  - Branch encodings BR_NONE/BR_TAKEN/BR_JUMP/BR_JR
  - fetch state enum {FETCH, HELD, DROP}
- Sub-module ifid_reg holds the IF/ID register (Instr, PC4, Valid), with write-enable, flush and async reset. Decode-side flush reuse depends on it being a separate module.
- PC, FSM, hold buffer and pending-target register live in fetch_stage.

## Test plan
- Zero-wait memory, RESET_PC=0, no hazards, 4 cycles → IFID_PC4 = 4, 8, 12, 16, all Valid=1.
- PCWrite=IFIDWrite=0 for 2 cycles with PC=8 → PC stays 8, IF/ID holds. The instruction at 8 enters IF/ID on the first free edge, and nothing is duplicated.
- Branch=01, BranchTarget=0x40 at PC=0x10 → IFID_Valid=0 next cycle, imem_addr=0x40, and the following IF/ID has PC4=0x44.
- Ready delayed 3 cycles, Branch=10 to 0x80 during the wait → imem_addr stays at the old address until ready, that response is dropped, and the next fetch is at 0x80.
- PC=0xFFFF_FFFC, normal fetch → IFID_PC4=0, next imem_addr=0.
- Reset asserted in HELD → all outputs at reset values immediately, and the first post-reset fetch is at RESET_PC.
